// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the byte serializer: FSM encoding, frame length and the
// data-bit to mux-select mapping imposed by the 8:1 mux stage.
package mux_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;

  // The mux stage routes the upper nibble when S[2]=0, so the nibble bit is inverted.
  function automatic logic [2:0] sel_of(input logic [2:0] k);
    return {~k[2], k[1:0]};
  endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// Producer-side byte handshake plus the serial line and frame status outputs.
interface mux_serializer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       busy;
  logic       frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, busy, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, busy, frame_done
  );
endinterface

// File: rtl/mux_serializer_mux8_1.sv
// 8:1 bit-select mux with the hardware select mapping: S[2]=0 picks the upper nibble.
module mux8_1 (
  input  logic [7:0] a,
  input  logic [2:0] s,
  output logic       y
);
  assign y = a[{~s[2], s[1:0]}];
endmodule

// File: rtl/mux_serializer.sv
// Byte-to-bitstream serializer: start bit, 8 data bits via the 8:1 mux, stop bit,
// each held BIT_DIV clocks on a registered line.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int unsigned BIT_DIV   = 16,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          IDLE_LVL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_serializer_if.slave  bus
);

  localparam logic [15:0] DIV_LAST = 16'(BIT_DIV - 1);

  state_t      state;
  logic [7:0]  data_q;
  logic [2:0]  bit_idx;
  logic [2:0]  sel_q;
  logic [15:0] div_cnt;
  logic [15:0] div_nxt;
  logic        bit_end;
  logic        mux_y;
  logic        handshake;

  function automatic logic [2:0] k_of(input logic [2:0] idx);
    return LSB_FIRST ? idx : ~idx;
  endfunction

  assign bit_end   = (div_cnt == DIV_LAST);
  assign div_nxt   = bit_end ? 16'd0 : div_cnt + 16'd1;
  assign handshake = bus.in_valid && bus.in_ready;

  mux8_1 u_mux (
    .a (data_q),
    .s (sel_q),
    .y (mux_y)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      data_q         <= '0;
      bit_idx        <= '0;
      sel_q          <= '0;
      div_cnt        <= '0;
      bus.ser_out    <= IDLE_LVL;
      bus.in_ready   <= 1'b1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      unique case (state)
        IDLE: ;
        START: begin
          div_cnt <= div_nxt;
          if (bit_end) begin
            state       <= DATA;
            bit_idx     <= 3'd0;
            bus.ser_out <= mux_y;
            sel_q       <= sel_of(k_of(3'd1));
          end
        end
        DATA: begin
          div_cnt <= div_nxt;
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state       <= STOP;
              bus.ser_out <= IDLE_LVL;
              if (BIT_DIV == 1) begin
                bus.frame_done <= 1'b1;
                bus.in_ready   <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              bus.ser_out <= mux_y;
              // Select runs one bit ahead so the mux has settled by the next boundary.
              sel_q       <= sel_of(k_of(bit_idx + 3'd2));
            end
          end
        end
        STOP: begin
          div_cnt <= div_nxt;
          if (bit_end) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.in_ready <= 1'b1;
          end else if (div_cnt == DIV_LAST - 16'd1) begin
            bus.frame_done <= 1'b1;
            bus.in_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: placed after the case so a handshake in the last STOP cycle overrides the return to IDLE.
      if (handshake) begin
        data_q       <= bus.in_data;
        state        <= START;
        div_cnt      <= '0;
        sel_q        <= sel_of(k_of(3'd0));
        bus.ser_out  <= ~IDLE_LVL;
        bus.busy     <= 1'b1;
        bus.in_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: three instances cover BIT_DIV=4 LSB-first,
// BIT_DIV=4 MSB-first and BIT_DIV=1 back-to-back operation.
module tb_mux_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] din [3];
  logic       vld [3];
  logic       so  [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       fd  [3];

  mux_serializer_if if_a ();
  mux_serializer_if if_b ();
  mux_serializer_if if_c ();

  assign if_a.in_data = din[0];
  assign if_a.in_valid = vld[0];
  assign if_b.in_data = din[1];
  assign if_b.in_valid = vld[1];
  assign if_c.in_data = din[2];
  assign if_c.in_valid = vld[2];
  assign so[0] = if_a.ser_out;
  assign so[1] = if_b.ser_out;
  assign so[2] = if_c.ser_out;
  assign rdy[0] = if_a.in_ready;
  assign rdy[1] = if_b.in_ready;
  assign rdy[2] = if_c.in_ready;
  assign bsy[0] = if_a.busy;
  assign bsy[1] = if_b.busy;
  assign bsy[2] = if_c.busy;
  assign fd[0] = if_a.frame_done;
  assign fd[1] = if_b.frame_done;
  assign fd[2] = if_c.frame_done;

  mux_serializer #(.BIT_DIV(4), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (if_a));
  mux_serializer #(.BIT_DIV(4), .LSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (if_b));
  mux_serializer #(.BIT_DIV(1), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_c (
    .clk (clk), .rst_n (rst_n), .bus (if_c));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level in frame slot 0..9 (idle level is 1).
  function automatic logic exp_level(input logic [7:0] b, input bit lsb, input int slot);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return lsb ? b[slot-1] : b[8-slot];
  endfunction

  // Called at a negedge with instance u idle; checks the whole frame and the return to idle.
  task automatic send_frame(input int u, input logic [7:0] b, input int div, input bit lsb,
                            input bit churn, input string tag);
    int n;
    n = 10 * div;
    din[u] = b;
    vld[u] = 1'b1;
    @(negedge clk);
    if (!churn) vld[u] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s ser_out[%0d]", tag, i), 32'(so[u]), 32'(exp_level(b, lsb, i / div)));
      check($sformatf("%s frame_done[%0d]", tag, i), 32'(fd[u]), 32'(i == n - 1));
      check($sformatf("%s busy[%0d]", tag, i), 32'(bsy[u]), 32'd1);
      if (i == n / 2) check($sformatf("%s in_ready mid", tag), 32'(rdy[u]), 32'd0);
      if (churn) begin
        din[u] = 8'($urandom);
        if (i == n - 2) vld[u] = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("%s busy after", tag), 32'(bsy[u]), 32'd0);
    check($sformatf("%s ser_out after", tag), 32'(so[u]), 32'd1);
    check($sformatf("%s in_ready after", tag), 32'(rdy[u]), 32'd1);
  endtask

  initial begin
    int fd_cnt;
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      din[u] = 8'h00;
      vld[u] = 1'b0;
    end

    // 1: reset and idle line
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst ser_out u%0d", u), 32'(so[u]), 32'd1);
      check($sformatf("rst in_ready u%0d", u), 32'(rdy[u]), 32'd1);
      check($sformatf("rst busy u%0d", u), 32'(bsy[u]), 32'd0);
      check($sformatf("rst frame_done u%0d", u), 32'(fd[u]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("idle ser_out u%0d", u), 32'(so[u]), 32'd1);
      check($sformatf("idle busy u%0d", u), 32'(bsy[u]), 32'd0);
    end

    // 2: 0xA5, BIT_DIV=4, LSB first -> 0,1,0,1,0,0,1,0,1,1
    send_frame(0, 8'hA5, 4, 1'b1, 1'b0, "t2");

    // 3: 0x01 MSB first -> start, seven 0s, 1, stop
    send_frame(1, 8'h01, 4, 1'b0, 1'b0, "t3");

    // 4: back-to-back 0xFF then 0x00 at BIT_DIV=1 with in_valid held
    din[2] = 8'hFF;
    vld[2] = 1'b1;
    fd_cnt = 0;
    @(negedge clk);
    din[2] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t4 ser_out[%0d]", i), 32'(so[2]),
            32'((i < 10) ? exp_level(8'hFF, 1'b1, i) : exp_level(8'h00, 1'b1, i - 10)));
      check($sformatf("t4 busy[%0d]", i), 32'(bsy[2]), 32'd1);
      check($sformatf("t4 frame_done[%0d]", i), 32'(fd[2]), 32'((i % 10) == 9));
      if (fd[2] === 1'b1) fd_cnt++;
      if (i == 18) vld[2] = 1'b0;
    end
    check("t4 frame_done count", 32'(fd_cnt), 32'd2);
    @(negedge clk);
    check("t4 busy after", 32'(bsy[2]), 32'd0);
    check("t4 ser_out after", 32'(so[2]), 32'd1);

    // 5: in_data churns and in_valid stays high while busy
    send_frame(0, 8'h3C, 4, 1'b1, 1'b1, "t5");

    // 6: reset during data bit 3, then a clean frame
    din[0] = 8'h00;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t6 ser_out[%0d]", i), 32'(so[0]), 32'(exp_level(8'h00, 1'b1, i / 4)));
    end
    rst_n = 1'b0;
    #1;
    check("t6 async ser_out", 32'(so[0]), 32'd1);
    check("t6 async busy", 32'(bsy[0]), 32'd0);
    check("t6 async frame_done", 32'(fd[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("t6 held frame_done", 32'(fd[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 in_ready after", 32'(rdy[0]), 32'd1);
    check("t6 ser_out after", 32'(so[0]), 32'd1);
    check("t6 frame_done after", 32'(fd[0]), 32'd0);
    send_frame(0, 8'h5A, 4, 1'b1, 1'b0, "t6 next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
